// File: rtl/hazard_pkg.sv
`default_nettype none
// hazard_pkg: forwarding encodings, FSM state type, producer slot and counter width
// shared by the hazard controller and its forwarding selectors.
package hazard_pkg;

  localparam int CNT_W = 16;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       load;
  } slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// fwd_sel: picks the youngest in-flight producer of one source operand and
// flags a match against a load still sitting in EX.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_use,
  input  slot_t      i_ex,
  input  slot_t      i_mem,
  input  slot_t      i_wb,
  output logic [1:0] o_fwd,
  output logic       o_load_hit
);

  logic w_src_live;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;
  logic w_unused;

  assign w_src_live = i_use && (i_src != 5'd0);
  assign w_hit_ex   = w_src_live && i_ex.valid  && (i_ex.dst  == i_src);
  assign w_hit_mem  = w_src_live && i_mem.valid && (i_mem.dst == i_src);
  assign w_hit_wb   = w_src_live && i_wb.valid  && (i_wb.dst  == i_src);
  assign w_unused   = ^{i_mem.load, i_wb.load};

  // A load in EX has no data yet, so its match falls through to older slots.
  always_comb begin
    o_fwd = FWD_REG;
    if (w_hit_ex && !i_ex.load) begin
      o_fwd = FWD_EX;
    end else if (w_hit_mem) begin
      o_fwd = FWD_MEM;
    end else if (w_hit_wb) begin
      o_fwd = FWD_WB;
    end
  end

  assign o_load_hit = w_hit_ex && i_ex.load;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: 5-stage pipeline hazard unit -- forwarding, load-use stall,
// branch flush, syscall drain/halt FSM and saturating event counters.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_r1_pos,
  input  logic [4:0]       id_r2_pos,
  input  logic             id_use_r1,
  input  logic             id_use_r2,
  input  logic [4:0]       id_dst,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             id_syscall,
  input  logic             ex_br_taken,
  input  logic             resume,
  output logic             stall_pc,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  slot_t            r_ex, r_mem, r_wb;
  slot_t            w_ex_nxt;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_lh_a, w_lh_b;
  logic             w_flush, w_load_use, w_all_empty;
  logic             w_stall, w_bubble, w_halted;

  fwd_sel u_fwd_a (
    .i_src      (id_r1_pos),
    .i_use      (id_use_r1),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_fwd      (fwd_a),
    .o_load_hit (w_lh_a)
  );

  fwd_sel u_fwd_b (
    .i_src      (id_r2_pos),
    .i_use      (id_use_r2),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_fwd      (fwd_b),
    .o_load_hit (w_lh_b)
  );

  // Gated by rst_n so the flush output is quiet while reset is held.
  assign w_flush     = ex_br_taken & rst_n;
  assign w_load_use  = (w_lh_a | w_lh_b) & (r_state == ST_RUN) & ~w_flush;
  assign w_all_empty = ~(r_ex.valid | r_mem.valid | r_wb.valid);

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = w_load_use;
    w_bubble    = w_flush | w_load_use;
    w_halted    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (id_valid && id_syscall && !w_load_use && !w_flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (w_all_empty) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_halted = 1'b1;
        if (resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_ex_nxt = '0;
    if (!w_bubble) begin
      w_ex_nxt.valid = id_valid & id_we & (id_dst != 5'd0);
      w_ex_nxt.dst   = id_dst;
      w_ex_nxt.load  = id_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ex    <= w_ex_nxt;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
      if (w_load_use && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_pc    = w_stall;
  assign bubble_idex = w_bubble;
  assign flush_ifid  = w_flush;
  assign halted      = w_halted;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// tb_hazard_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the pipeline's in-flight producers.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, id_use_r1, id_use_r2, id_we, id_load, id_syscall;
  logic [4:0]  id_r1_pos, id_r2_pos, id_dst;
  logic        ex_br_taken, resume;
  logic        stall_pc, flush_ifid, bubble_idex, halted;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int n_pass = 0;
  int n_total = 0;

  // model: index 0 = EX (youngest), 2 = WB (oldest); mode 0 RUN, 1 DRAIN, 2 HALT
  bit         mv[3];
  logic [4:0] md[3];
  bit         ml[3];
  int         mmode, msc, mfc;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_r1_pos(id_r1_pos), .id_r2_pos(id_r2_pos),
    .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_dst(id_dst),
    .id_we(id_we), .id_load(id_load), .id_syscall(id_syscall),
    .ex_br_taken(ex_br_taken), .resume(resume),
    .stall_pc(stall_pc), .flush_ifid(flush_ifid), .bubble_idex(bubble_idex),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle();
    id_valid = 0; id_r1_pos = 0; id_r2_pos = 0; id_use_r1 = 0; id_use_r2 = 0;
    id_dst = 0; id_we = 0; id_load = 0; id_syscall = 0; ex_br_taken = 0; resume = 0;
  endtask

  task automatic instr(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] dst, input logic we,
                       input logic ld, input logic sc);
    id_valid = 1; id_r1_pos = r1; id_use_r1 = u1; id_r2_pos = r2; id_use_r2 = u2;
    id_dst = dst; id_we = we; id_load = ld; id_syscall = sc;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    ex_br_taken = 1; resume = 1;
    #2;
    n_total++;
    if ({stall_pc, flush_ifid, bubble_idex, halted, fwd_a, fwd_b} !== 8'h00)
      $display("FAIL reset_outputs: got %b expected 00000000",
               {stall_pc, flush_ifid, bubble_idex, halted, fwd_a, fwd_b});
    else n_pass++;
    n_total++;
    if ({stall_cnt, flush_cnt} !== 32'h0)
      $display("FAIL reset_counters: stall_cnt=%0d flush_cnt=%0d expected 0/0", stall_cnt, flush_cnt);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    instr(0, 1, 0, 0, 8, 1, 1, 0);
    #1;
    n_total++;
    if ({stall_pc, bubble_idex} !== 2'b00)
      $display("FAIL lu_load_issue: stall/bubble=%b expected 00", {stall_pc, bubble_idex});
    else n_pass++;
    @(negedge clk);
    instr(8, 1, 8, 1, 9, 1, 0, 0);
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, flush_ifid} !== 3'b110)
      $display("FAIL lu_stall: stall/bubble/flush=%b expected 110", {stall_pc, bubble_idex, flush_ifid});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, fwd_a, fwd_b} !== 6'b001010)
      $display("FAIL lu_resolve: stall/bubble/fwd_a/fwd_b=%b expected 001010",
               {stall_pc, bubble_idex, fwd_a, fwd_b});
    else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_total++;
    if (stall_cnt !== 16'd1)
      $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
    else n_pass++;
  endtask

  task automatic test_forward();
    do_reset();
    instr(1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clk);
    instr(3, 1, 0, 1, 4, 1, 0, 0);
    #1;
    n_total++;
    if ({stall_pc, fwd_a, fwd_b} !== 5'b00100)
      $display("FAIL fwd_ex: stall/fwd_a/fwd_b=%b expected 00100", {stall_pc, fwd_a, fwd_b});
    else n_pass++;
    do_reset();
    instr(1, 1, 2, 1, 3, 1, 0, 0);
    @(negedge clk);
    instr(1, 1, 2, 1, 10, 1, 0, 0);
    @(negedge clk);
    instr(2, 1, 1, 1, 11, 1, 0, 0);
    @(negedge clk);
    instr(3, 1, 0, 1, 4, 1, 0, 0);
    #1;
    n_total++;
    if ({stall_pc, fwd_a, fwd_b} !== 5'b01100)
      $display("FAIL fwd_wb: stall/fwd_a/fwd_b=%b expected 01100", {stall_pc, fwd_a, fwd_b});
    else n_pass++;
  endtask

  task automatic test_branch_override();
    do_reset();
    instr(0, 1, 0, 0, 8, 1, 1, 0);
    @(negedge clk);
    instr(8, 1, 8, 1, 9, 1, 0, 0);
    ex_br_taken = 1;
    #1;
    n_total++;
    if ({flush_ifid, bubble_idex, stall_pc} !== 3'b110)
      $display("FAIL br_override: flush/bubble/stall=%b expected 110", {flush_ifid, bubble_idex, stall_pc});
    else n_pass++;
    @(negedge clk);
    idle();
    #1;
    n_total++;
    if ({flush_cnt, stall_cnt} !== {16'd1, 16'd0})
      $display("FAIL br_counters: flush_cnt=%0d stall_cnt=%0d expected 1/0", flush_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_syscall_halt();
    do_reset();
    instr(0, 0, 0, 0, 5, 1, 0, 0);
    @(negedge clk);
    instr(0, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk);
    instr(0, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk);
    instr(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    n_total++;
    if ({stall_pc, halted} !== 2'b00)
      $display("FAIL sys_issue: stall/halted=%b expected 00", {stall_pc, halted});
    else n_pass++;
    @(negedge clk);
    idle();
    resume = 1;
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, halted} !== 3'b110)
      $display("FAIL drain_1: stall/bubble/halted=%b expected 110", {stall_pc, bubble_idex, halted});
    else n_pass++;
    @(negedge clk);
    resume = 0;
    ex_br_taken = 1;
    #1;
    n_total++;
    if ({stall_pc, flush_ifid, bubble_idex, halted} !== 4'b1110)
      $display("FAIL drain_2_branch: stall/flush/bubble/halted=%b expected 1110",
               {stall_pc, flush_ifid, bubble_idex, halted});
    else n_pass++;
    @(negedge clk);
    ex_br_taken = 0;
    #1;
    n_total++;
    if ({stall_pc, halted} !== 2'b10)
      $display("FAIL drain_3: stall/halted=%b expected 10", {stall_pc, halted});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, halted} !== 3'b111)
      $display("FAIL halt_enter: stall/bubble/halted=%b expected 111", {stall_pc, bubble_idex, halted});
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (halted !== 1'b1)
      $display("FAIL halt_hold: halted=%b expected 1", halted);
    else n_pass++;
    resume = 1;
    @(negedge clk);
    resume = 0;
    #1;
    n_total++;
    if ({halted, stall_pc} !== 2'b00)
      $display("FAIL resume: halted/stall=%b expected 00", {halted, stall_pc});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int k;
    do_reset();
    instr(0, 1, 0, 0, 8, 1, 1, 0);
    @(negedge clk);
    instr(8, 1, 8, 1, 9, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    idle();
    ex_br_taken = 1;
    @(negedge clk);
    idle();
    instr(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    idle();
    k = 0;
    #1;
    while (!halted && k < 8) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_total++;
    if ({halted, stall_cnt, flush_cnt} !== {1'b1, 16'd1, 16'd1})
      $display("FAIL pre_reset_halt: halted=%b stall_cnt=%0d flush_cnt=%0d expected 1/1/1",
               halted, stall_cnt, flush_cnt);
    else n_pass++;
    #1;
    rst_n = 0;
    #1;
    n_total++;
    if ({stall_pc, flush_ifid, bubble_idex, halted, fwd_a, fwd_b, stall_cnt, flush_cnt} !== 40'h0)
      $display("FAIL async_reset: stall/flush/bubble/halted=%b cnt=%0d/%0d expected all zero",
               {stall_pc, flush_ifid, bubble_idex, halted}, stall_cnt, flush_cnt);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, halted} !== 3'b000)
      $display("FAIL post_reset_run: stall/bubble/halted=%b expected 000", {stall_pc, bubble_idex, halted});
    else n_pass++;
  endtask

  task automatic test_reg0();
    do_reset();
    instr(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    instr(0, 1, 0, 1, 5, 1, 0, 0);
    #1;
    n_total++;
    if ({stall_pc, bubble_idex, fwd_a, fwd_b} !== 6'b000000)
      $display("FAIL reg0_ex: stall/bubble/fwd_a/fwd_b=%b expected 000000",
               {stall_pc, bubble_idex, fwd_a, fwd_b});
    else n_pass++;
    @(negedge clk);
    instr(0, 1, 0, 1, 6, 1, 0, 0);
    #1;
    n_total++;
    if ({stall_pc, fwd_a, fwd_b} !== 5'b00000)
      $display("FAIL reg0_mem: stall/fwd_a/fwd_b=%b expected 00000", {stall_pc, fwd_a, fwd_b});
    else n_pass++;
  endtask

  // {load_hit, fwd}: scan oldest to youngest so the youngest usable producer wins.
  function automatic logic [2:0] ref_src(input logic [4:0] s, input logic u);
    logic [2:0] r;
    r = 3'b000;
    if (u && s != 5'd0) begin
      for (int k = 2; k >= 0; k--) begin
        if (mv[k] && md[k] == s && !(k == 0 && ml[k])) r[1:0] = 2'(k + 1);
      end
      if (mv[0] && md[0] == s && ml[0]) r[2] = 1'b1;
    end
    return r;
  endfunction

  task automatic test_random();
    logic [2:0] ra, rb;
    logic [7:0] exp_out;
    bit         lu, bub, empty;
    int         nmode;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 0; md[k] = 0; ml[k] = 0;
    end
    mmode = 0; msc = 0; mfc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid    = ($urandom_range(0, 7) != 0);
      id_r1_pos   = 5'($urandom_range(0, 3));
      id_r2_pos   = 5'($urandom_range(0, 3));
      id_use_r1   = 1'($urandom_range(0, 1));
      id_use_r2   = 1'($urandom_range(0, 1));
      id_dst      = 5'($urandom_range(0, 3));
      id_we       = ($urandom_range(0, 3) != 0);
      id_load     = ($urandom_range(0, 2) == 0);
      id_syscall  = ($urandom_range(0, 15) == 0);
      ex_br_taken = ($urandom_range(0, 7) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      #1;
      ra  = ref_src(id_r1_pos, id_use_r1);
      rb  = ref_src(id_r2_pos, id_use_r2);
      lu  = (mmode == 0) && !ex_br_taken && (ra[2] || rb[2]);
      bub = ex_br_taken || lu || (mmode != 0);
      exp_out = {lu || (mmode != 0), ex_br_taken, bub, mmode == 2, ra[1:0], rb[1:0]};
      n_total++;
      if ({stall_pc, flush_ifid, bubble_idex, halted, fwd_a, fwd_b} !== exp_out ||
          stall_cnt !== 16'(msc) || flush_cnt !== 16'(mfc))
        $display("FAIL random_cycle_%0d: outs=%b cnt=%0d/%0d expected outs=%b cnt=%0d/%0d", cyc,
                 {stall_pc, flush_ifid, bubble_idex, halted, fwd_a, fwd_b}, stall_cnt, flush_cnt,
                 exp_out, msc, mfc);
      else n_pass++;
      empty = !mv[0] && !mv[1] && !mv[2];
      nmode = mmode;
      if (mmode == 0 && id_valid && id_syscall && !lu && !ex_br_taken) nmode = 1;
      else if (mmode == 1 && empty) nmode = 2;
      else if (mmode == 2 && resume) nmode = 0;
      @(negedge clk);
      mv[2] = mv[1]; md[2] = md[1]; ml[2] = ml[1];
      mv[1] = mv[0]; md[1] = md[0]; ml[1] = ml[0];
      mv[0] = !bub && id_valid && id_we && (id_dst != 5'd0);
      md[0] = id_dst;
      ml[0] = id_load;
      mmode = nmode;
      if (lu && msc < 65535) msc++;
      if (ex_br_taken && mfc < 65535) mfc++;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_forward();
    test_branch_override();
    test_syscall_halt();
    test_async_reset();
    test_reg0();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
